vga_fb_scanout: RTL and testbench

//  Parametrised VGA scan-out engine: generates hsync/vsync timing, reads RGB444 pixels from the
//  16-bit framebuffer block RAM via its read port, and drives the 4:4:4 VGA pins. Adds pixel

---
 rtl/vga_fb_scanout.sv | 223 ++++++++++++++++++++++
 tb/tb_vga_fb_scanout.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_scanout.sv
// VGA scan-out engine: raster counters, replicated-pixel framebuffer addressing,
// colour-bar / solid-colour test patterns and a pin stage aligned to the RAM read latency.
module vga_fb_scanout #(
    parameter int   H_SYNC      = 80,
    parameter int   H_BACK      = 160,
    parameter int   H_ACTIVE    = 800,
    parameter int   H_FRONT     = 16,
    parameter int   V_SYNC      = 3,
    parameter int   V_BACK      = 21,
    parameter int   V_ACTIVE    = 600,
    parameter int   V_FRONT     = 1,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   SCALE_SHIFT = 5,
    parameter int   ADDR_W      = 10,
    parameter int   RAM_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [11:0]       bg_color,
    output logic              fb_en,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [15:0]       fb_dout,
    output logic              hsync,
    output logic              vsync,
    output logic [3:0]        vgared,
    output logic [3:0]        vgagreen,
    output logic [3:0]        vgablue,
    output logic              frame_start
);

    localparam int HT    = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int VT    = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW    = $clog2(HT);
    localparam int VW    = $clog2(VT);
    localparam int FB_W  = H_ACTIVE >> SCALE_SHIFT;
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = $clog2(BAR_W + 1);

    localparam logic [HW-1:0]     HC_SYNC   = HW'(H_SYNC);
    localparam logic [HW-1:0]     HC_START  = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0]     HC_LAST   = HW'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [HW-1:0]     HC_MAX    = HW'(HT - 1);
    localparam logic [VW-1:0]     VC_SYNC   = VW'(V_SYNC);
    localparam logic [VW-1:0]     VC_START  = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0]     VC_LAST   = VW'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [VW-1:0]     VC_MAX    = VW'(VT - 1);
    localparam logic [VW-1:0]     Y_MASK    = VW'((1 << SCALE_SHIFT) - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(FB_W);
    localparam logic [BW-1:0]     BAR_LAST  = BW'(BAR_W - 1);

    // Control word carried alongside the RAM read:
    // [16] frame start, [15] active, [14] hsync level, [13] vsync level,
    // [12] take colour from RAM, [11:0] pattern colour.
    localparam int             CW      = 17;
    localparam logic [CW-1:0]  CTL_RST = {2'b00, ~SYNC_POL, ~SYNC_POL, 13'd0};

    logic [HW-1:0]     r_hcnt;
    logic [VW-1:0]     r_vcnt;
    logic [BW-1:0]     r_bar_pos;
    logic [2:0]        r_bar_idx;
    logic [1:0]        r_mode;
    logic [11:0]       r_bg;
    logic [ADDR_W-1:0] r_line_base;
    logic [ADDR_W-1:0] r_fb_addr;
    logic [CW-1:0]     r_s1_ctl;
    logic [CW-1:0]     r_dly [RAM_LAT];
    logic              r_hsync;
    logic              r_vsync;
    logic              r_fs;
    logic [11:0]       r_rgb;

    logic              w_origin;
    logic              w_act;
    logic [HW-1:0]     w_xa;
    logic [VW-1:0]     w_ya;
    logic              w_row_done;
    logic              w_frame_end;
    logic [1:0]        w_mode;
    logic [11:0]       w_bg;
    logic [11:0]       w_bar_rgb;
    logic [11:0]       w_pat_rgb;
    logic              w_hs;
    logic              w_vs;
    logic [CW-1:0]     w_ctl;
    logic [CW-1:0]     w_tail;
    logic              w_unused_msb;

    assign w_origin    = (r_hcnt == '0) && (r_vcnt == '0);
    assign w_act       = (r_hcnt >= HC_START) && (r_hcnt <= HC_LAST) &&
                         (r_vcnt >= VC_START) && (r_vcnt <= VC_LAST);
    assign w_xa        = r_hcnt - HC_START;
    assign w_ya        = r_vcnt - VC_START;
    assign w_row_done  = w_act && (r_hcnt == HC_LAST) && (((w_ya + VW'(1)) & Y_MASK) == '0);
    assign w_frame_end = (r_hcnt == HC_MAX) && (r_vcnt == VC_MAX);

    // The pixel at the frame origin already sees the freshly sampled mode/colour.
    assign w_mode      = w_origin ? mode : r_mode;
    assign w_bg        = w_origin ? bg_color : r_bg;
    assign w_bar_rgb   = {{4{r_bar_idx[2]}}, {4{r_bar_idx[1]}}, {4{r_bar_idx[0]}}};
    assign w_pat_rgb   = (w_mode == 2'd1) ? w_bar_rgb : w_bg;
    assign w_hs        = (r_hcnt < HC_SYNC) ? SYNC_POL : ~SYNC_POL;
    assign w_vs        = (r_vcnt < VC_SYNC) ? SYNC_POL : ~SYNC_POL;
    assign w_ctl       = {w_origin, w_act, w_hs, w_vs, (w_mode == 2'd0), w_pat_rgb};
    assign w_tail      = r_dly[RAM_LAT-1];

    // Upper nibble of the RAM word carries no colour information.
    assign w_unused_msb = ^fb_dout[15:12];

    // Raster position: horizontal count wraps into the vertical count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (en) begin
            if (r_hcnt == HC_MAX) begin
                r_hcnt <= '0;
                r_vcnt <= (r_vcnt == VC_MAX) ? '0 : r_vcnt + VW'(1);
            end else begin
                r_hcnt <= r_hcnt + HW'(1);
            end
        end
    end

    // Colour-bar index follows the active x position without a divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bar_pos <= '0;
            r_bar_idx <= '0;
        end else if (en) begin
            if (!w_act) begin
                r_bar_pos <= '0;
                r_bar_idx <= '0;
            end else if (r_bar_pos == BAR_LAST) begin
                r_bar_pos <= '0;
                r_bar_idx <= r_bar_idx + 3'd1;
            end else begin
                r_bar_pos <= r_bar_pos + BW'(1);
            end
        end
    end

    // Mode and solid colour are latched once per frame so changes land on a frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= mode;
            r_bg   <= bg_color;
        end else if (en && w_origin) begin
            r_mode <= mode;
            r_bg   <= bg_color;
        end
    end

    // Framebuffer row start: advances one FB row after every 2^S active screen lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_line_base <= '0;
        end else if (en) begin
            if (w_frame_end) begin
                r_line_base <= '0;
            end else if (w_row_done) begin
                r_line_base <= r_line_base + LINE_STEP;
            end
        end
    end

    // Stage 1: registered RAM address and the control word for this pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fb_addr <= '0;
            r_s1_ctl  <= CTL_RST;
        end else if (en) begin
            r_fb_addr <= w_act ? r_line_base + ADDR_W'(w_xa >> SCALE_SHIFT) : r_line_base;
            r_s1_ctl  <= w_ctl;
        end
    end

    // Control delay matching the RAM read latency so colour and syncs stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAM_LAT; i++) begin
                r_dly[i] <= CTL_RST;
            end
        end else if (en) begin
            r_dly[0] <= r_s1_ctl;
            for (int i = 1; i < RAM_LAT; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    // Pin register: blank outside the active window, otherwise RAM or pattern colour.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
            r_fs    <= 1'b0;
            r_rgb   <= '0;
        end else if (en) begin
            r_hsync <= w_tail[14];
            r_vsync <= w_tail[13];
            r_fs    <= w_tail[16];
            if (!w_tail[15]) begin
                r_rgb <= '0;
            end else if (w_tail[12]) begin
                r_rgb <= fb_dout[11:0];
            end else begin
                r_rgb <= w_tail[11:0];
            end
        end
    end

    assign fb_en       = en;
    assign fb_addr     = r_fb_addr;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_start = r_fs;
    assign vgared      = r_rgb[11:8];
    assign vgagreen    = r_rgb[7:4];
    assign vgablue     = r_rgb[3:0];

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout: two instances on a shrunken raster (RAM_LAT 1 / active-low
// syncs and RAM_LAT 2 / active-high syncs) compared against a position-based reference model.
module tb_vga_fb_scanout;

    localparam int H_SYNC = 4, H_BACK = 5, H_ACTIVE = 32, H_FRONT = 3;
    localparam int V_SYNC = 2, V_BACK = 2, V_ACTIVE = 12, V_FRONT = 1;
    localparam int HT = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int VT = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int FRAME = HT * VT;
    localparam int H0 = H_SYNC + H_BACK;
    localparam int V0 = V_SYNC + V_BACK;
    localparam int S = 2;
    localparam int SCALE = 1 << S;
    localparam int FB_W = H_ACTIVE / SCALE;
    localparam int ADDR_W = 4;
    localparam int MEM_N = 1 << ADDR_W;
    localparam int L1 = 3, L2 = 4;
    localparam logic POL1 = 1'b0, POL2 = 1'b1;

    typedef struct packed {
        logic              fs;
        logic              hs_on;
        logic              vs_on;
        logic [11:0]       rgb;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    logic clk, rst, en;
    logic [1:0]  mode;
    logic [11:0] bg_color;

    logic fb_en1, fb_en2, hsync1, hsync2, vsync1, vsync2, fs1, fs2;
    logic [ADDR_W-1:0] fb_addr1, fb_addr2;
    logic [15:0] fb_dout1, fb_dout2;
    logic [3:0] red1, green1, blue1, red2, green2, blue2;

    logic [15:0] mem [MEM_N];
    logic [15:0] ram1_q, ram2_q0, ram2_q1;

    int   n_checks, n_errors;
    int   m_h, m_v;
    logic [1:0]  m_mode;
    logic [11:0] m_bg;
    exp_t hist [4];

    logic [18:0] got1, got2;
    assign got1 = {fs1, hsync1, vsync1, red1, green1, blue1, fb_addr1};
    assign got2 = {fs2, hsync2, vsync2, red2, green2, blue2, fb_addr2};

    vga_fb_scanout #(
        .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT),
        .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT),
        .SYNC_POL(POL1), .SCALE_SHIFT(S), .ADDR_W(ADDR_W), .RAM_LAT(1)
    ) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .bg_color(bg_color),
        .fb_en(fb_en1), .fb_addr(fb_addr1), .fb_dout(fb_dout1),
        .hsync(hsync1), .vsync(vsync1), .vgared(red1), .vgagreen(green1),
        .vgablue(blue1), .frame_start(fs1)
    );

    vga_fb_scanout #(
        .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT),
        .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT),
        .SYNC_POL(POL2), .SCALE_SHIFT(S), .ADDR_W(ADDR_W), .RAM_LAT(2)
    ) dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .bg_color(bg_color),
        .fb_en(fb_en2), .fb_addr(fb_addr2), .fb_dout(fb_dout2),
        .hsync(hsync2), .vsync(vsync2), .vgared(red2), .vgagreen(green2),
        .vgablue(blue2), .frame_start(fs2)
    );

    // Free-running pixel clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block RAM models with one and two enabled cycles of read latency.
    always @(posedge clk) begin
        if (fb_en1) ram1_q <= mem[fb_addr1];
        if (fb_en2) begin
            ram2_q0 <= mem[fb_addr2];
            ram2_q1 <= ram2_q0;
        end
    end
    assign fb_dout1 = ram1_q;
    assign fb_dout2 = ram2_q1;

    // What the screen should show for raster position (h,v), derived from plain arithmetic.
    function automatic exp_t model_pos(int h, int v, logic [1:0] md, logic [11:0] bg);
        exp_t e;
        int xa, ya, rows, a, bar;
        bit act;
        logic [15:0] word;
        xa  = h - H0;
        ya  = v - V0;
        act = (xa >= 0) && (xa < H_ACTIVE) && (ya >= 0) && (ya < V_ACTIVE);
        if (ya < 0) rows = 0;
        else if (ya >= V_ACTIVE) rows = V_ACTIVE;
        else rows = ya + ((xa >= H_ACTIVE) ? 1 : 0);
        if (act) a = (ya / SCALE) * FB_W + xa / SCALE;
        else a = (rows / SCALE) * FB_W;
        a = a % MEM_N;
        bar = act ? xa / (H_ACTIVE / 8) : 0;
        word = mem[a];
        e.fs    = (h == 0) && (v == 0);
        e.hs_on = (h < H_SYNC);
        e.vs_on = (v < V_SYNC);
        e.addr  = ADDR_W'(a);
        if (!act) e.rgb = 12'h000;
        else if (md == 2'd0) e.rgb = word[11:0];
        else if (md == 2'd1) e.rgb = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
        else e.rgb = bg;
        return e;
    endfunction

    // Reference model: walks the raster on every enabled edge and keeps a short history.
    always @(posedge clk) begin
        if (rst) begin
            m_h = 0;
            m_v = 0;
            m_mode = mode;
            m_bg = bg_color;
            for (int i = 0; i < 4; i++) hist[i] = '0;
        end else if (en) begin
            if (m_h == 0 && m_v == 0) begin
                m_mode = mode;
                m_bg = bg_color;
            end
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = model_pos(m_h, m_v, m_mode, m_bg);
            m_h = m_h + 1;
            if (m_h == HT) begin
                m_h = 0;
                m_v = (m_v + 1) % VT;
            end
        end
    end

    // Expected pin vector for an instance of latency lat and sync polarity pol.
    function automatic logic [18:0] exp_vec(int lat, logic pol);
        exp_t e;
        e = hist[lat-1];
        return {e.fs, e.hs_on ? pol : ~pol, e.vs_on ? pol : ~pol, e.rgb, hist[0].addr};
    endfunction

    task automatic test_reset();
        logic [18:0] rv1, rv2;
        rv1 = {1'b0, ~POL1, ~POL1, 16'h0000};
        rv2 = {1'b0, ~POL2, ~POL2, 16'h0000};
        mode = 2'd1;
        bg_color = 12'($urandom);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            en = (k != 1);
            @(negedge clk);
            n_checks++;
            if (got1 !== rv1) begin n_errors++; $display("[TB] FAIL reset dut1 k=%0d got=%h want=%h", k, got1, rv1); end
            n_checks++;
            if (got2 !== rv2) begin n_errors++; $display("[TB] FAIL reset dut2 k=%0d got=%h want=%h", k, got2, rv2); end
        end
        rst = 1'b0;
        en = 1'b1;
    endtask

    task automatic test_frame_timing();
        int first1, first2, second1, second2, hs1, vs1, hs2, vs2;
        first1 = -1; first2 = -1; second1 = -1; second2 = -1;
        hs1 = 0; vs1 = 0; hs2 = 0; vs2 = 0;
        for (int k = 1; k <= FRAME + L2 + 1; k++) begin
            @(negedge clk);
            n_checks++;
            if (got1 !== exp_vec(L1, POL1)) begin n_errors++; $display("[TB] FAIL timing dut1 k=%0d got=%h want=%h", k, got1, exp_vec(L1, POL1)); end
            n_checks++;
            if (got2 !== exp_vec(L2, POL2)) begin n_errors++; $display("[TB] FAIL timing dut2 k=%0d got=%h want=%h", k, got2, exp_vec(L2, POL2)); end
            if (fs1) begin if (first1 < 0) first1 = k; else if (second1 < 0) second1 = k; end
            if (fs2) begin if (first2 < 0) first2 = k; else if (second2 < 0) second2 = k; end
            if (k >= L1 && k < L1 + FRAME) begin
                if (hsync1 == POL1) hs1++;
                if (vsync1 == POL1) vs1++;
            end
            if (k >= L2 && k < L2 + FRAME) begin
                if (hsync2 == POL2) hs2++;
                if (vsync2 == POL2) vs2++;
            end
        end
        n_checks++; if (first1 != L1) begin n_errors++; $display("[TB] FAIL fs_first dut1 got=%0d want=%0d", first1, L1); end
        n_checks++; if (first2 != L2) begin n_errors++; $display("[TB] FAIL fs_first dut2 got=%0d want=%0d", first2, L2); end
        n_checks++; if (second1 != L1 + FRAME) begin n_errors++; $display("[TB] FAIL fs_second dut1 got=%0d want=%0d", second1, L1 + FRAME); end
        n_checks++; if (second2 != L2 + FRAME) begin n_errors++; $display("[TB] FAIL fs_second dut2 got=%0d want=%0d", second2, L2 + FRAME); end
        n_checks++; if (hs1 != VT * H_SYNC) begin n_errors++; $display("[TB] FAIL hsync_count dut1 got=%0d want=%0d", hs1, VT * H_SYNC); end
        n_checks++; if (hs2 != VT * H_SYNC) begin n_errors++; $display("[TB] FAIL hsync_count dut2 got=%0d want=%0d", hs2, VT * H_SYNC); end
        n_checks++; if (vs1 != V_SYNC * HT) begin n_errors++; $display("[TB] FAIL vsync_count dut1 got=%0d want=%0d", vs1, V_SYNC * HT); end
        n_checks++; if (vs2 != V_SYNC * HT) begin n_errors++; $display("[TB] FAIL vsync_count dut2 got=%0d want=%0d", vs2, V_SYNC * HT); end
    endtask

    task automatic test_colour_bars();
        mode = 2'd1;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            n_checks++;
            if (got1 !== exp_vec(L1, POL1)) begin n_errors++; $display("[TB] FAIL bars dut1 k=%0d got=%h want=%h", k, got1, exp_vec(L1, POL1)); end
            n_checks++;
            if (got2 !== exp_vec(L2, POL2)) begin n_errors++; $display("[TB] FAIL bars dut2 k=%0d got=%h want=%h", k, got2, exp_vec(L2, POL2)); end
            en = ($urandom_range(0, 9) < 8);
        end
        en = 1'b1;
    endtask

    task automatic test_framebuffer();
        mode = 2'd0;
        for (int k = 0; k < 2 * FRAME + 50; k++) begin
            @(negedge clk);
            n_checks++;
            if (got1 !== exp_vec(L1, POL1)) begin n_errors++; $display("[TB] FAIL fb dut1 k=%0d got=%h want=%h", k, got1, exp_vec(L1, POL1)); end
            n_checks++;
            if (got2 !== exp_vec(L2, POL2)) begin n_errors++; $display("[TB] FAIL fb dut2 k=%0d got=%h want=%h", k, got2, exp_vec(L2, POL2)); end
            en = ($urandom_range(0, 9) < 9);
        end
        en = 1'b1;
    endtask

    task automatic test_enable_stall();
        logic [18:0] held1, held2;
        int guard;
        guard = 0;
        while (!(m_v == V0 + 2 && m_h == H0 + 12) && guard < 2 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (guard >= 2 * FRAME) begin n_errors++; $display("[TB] FAIL stall_wait got=%0d want<%0d", guard, 2 * FRAME); end
        held1 = got1;
        held2 = got2;
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (got1 !== held1) begin n_errors++; $display("[TB] FAIL freeze dut1 k=%0d got=%h want=%h", k, got1, held1); end
            n_checks++;
            if (got2 !== held2) begin n_errors++; $display("[TB] FAIL freeze dut2 k=%0d got=%h want=%h", k, got2, held2); end
        end
        en = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            n_checks++;
            if (got1 !== exp_vec(L1, POL1)) begin n_errors++; $display("[TB] FAIL resume dut1 k=%0d got=%h want=%h", k, got1, exp_vec(L1, POL1)); end
            n_checks++;
            if (got2 !== exp_vec(L2, POL2)) begin n_errors++; $display("[TB] FAIL resume dut2 k=%0d got=%h want=%h", k, got2, exp_vec(L2, POL2)); end
        end
    endtask

    task automatic test_mode_switch();
        int guard;
        mode = 2'd1;
        guard = 0;
        while (!(m_v == V0 + 5 && m_h == H0 + 3) && guard < 3 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (guard >= 3 * FRAME) begin n_errors++; $display("[TB] FAIL switch_wait got=%0d want<%0d", guard, 3 * FRAME); end
        mode = 2'd2;
        bg_color = 12'hF0F;
        for (int k = 0; k < FRAME + FRAME / 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (got1 !== exp_vec(L1, POL1)) begin n_errors++; $display("[TB] FAIL switch dut1 k=%0d got=%h want=%h", k, got1, exp_vec(L1, POL1)); end
            n_checks++;
            if (got2 !== exp_vec(L2, POL2)) begin n_errors++; $display("[TB] FAIL switch dut2 k=%0d got=%h want=%h", k, got2, exp_vec(L2, POL2)); end
        end
    endtask

    task automatic test_midline_reset();
        int guard, first1, first2;
        logic [18:0] rv1, rv2;
        rv1 = {1'b0, ~POL1, ~POL1, 16'h0000};
        rv2 = {1'b0, ~POL2, ~POL2, 16'h0000};
        mode = 2'd0;
        guard = 0;
        while (!(m_v == V0 + 6 && m_h == H0 + 20) && guard < 3 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (guard >= 3 * FRAME) begin n_errors++; $display("[TB] FAIL rst_wait got=%0d want<%0d", guard, 3 * FRAME); end
        rst = 1'b1;
        en = 1'($urandom_range(0, 1));
        @(negedge clk);
        n_checks++;
        if (got1 !== rv1) begin n_errors++; $display("[TB] FAIL midrst dut1 got=%h want=%h", got1, rv1); end
        n_checks++;
        if (got2 !== rv2) begin n_errors++; $display("[TB] FAIL midrst dut2 got=%h want=%h", got2, rv2); end
        rst = 1'b0;
        en = 1'b1;
        first1 = -1;
        first2 = -1;
        for (int k = 1; k <= FRAME + L2 + 1; k++) begin
            @(negedge clk);
            n_checks++;
            if (got1 !== exp_vec(L1, POL1)) begin n_errors++; $display("[TB] FAIL restart dut1 k=%0d got=%h want=%h", k, got1, exp_vec(L1, POL1)); end
            n_checks++;
            if (got2 !== exp_vec(L2, POL2)) begin n_errors++; $display("[TB] FAIL restart dut2 k=%0d got=%h want=%h", k, got2, exp_vec(L2, POL2)); end
            if (fs1 && first1 < 0) first1 = k;
            if (fs2 && first2 < 0) first2 = k;
        end
        n_checks++; if (first1 != L1) begin n_errors++; $display("[TB] FAIL restart_fs dut1 got=%0d want=%0d", first1, L1); end
        n_checks++; if (first2 != L2) begin n_errors++; $display("[TB] FAIL restart_fs dut2 got=%0d want=%0d", first2, L2); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3 * FRAME; k++) begin
            @(negedge clk);
            n_checks++;
            if (got1 !== exp_vec(L1, POL1)) begin n_errors++; $display("[TB] FAIL random dut1 k=%0d got=%h want=%h", k, got1, exp_vec(L1, POL1)); end
            n_checks++;
            if (got2 !== exp_vec(L2, POL2)) begin n_errors++; $display("[TB] FAIL random dut2 k=%0d got=%h want=%h", k, got2, exp_vec(L2, POL2)); end
            en  = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 199) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 99) == 0) bg_color = 12'($urandom);
        end
        rst = 1'b0;
        en = 1'b1;
    endtask

    // Test sequence.
    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        en = 1'b0;
        mode = 2'd1;
        bg_color = 12'h000;
        for (int i = 0; i < MEM_N; i++) mem[i] = 16'($urandom);
        test_reset();
        test_frame_timing();
        test_colour_bars();
        test_framebuffer();
        test_enable_stall();
        test_mode_switch();
        test_midline_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
